cpu_run_sequencer: RTL and testbench
====================================

CPU_RUN_SEQUENCER -- requirements
Module: cpu_run_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning width of the CPU in/out ports.
REQ-002 SHALL have parameter N_VEC, default 4, meaning number of test vectors per sequence (1..16).
REQ-003 SHALL have parameter RST_CYC, default 1, meaning CPU reset-hold cycles per vector (>=1).
REQ-004 SHALL have parameter RUN_CYC, default 50, meaning maximum CPU run cycles per vector (>=1).
REQ-005 SHALL have the following ports, clock and reset first:
  clk  input  1  single clock; all state updates on its rising edge
  reset  input  1  synchronous, active-low reset
  start  input  1  one-cycle pulse that begins a sequence; honoured only in IDLE
  early_exit  input  1  mode: 1 ends a vector's run as soon as cpu_out equals expected
  vec_in  input  N_VEC*DATA_W  stimulus value per vector; vector k occupies bits [k*DATA_W +: DATA_W]
  vec_exp  input  N_VEC*DATA_W  expected cpu_out per vector, same packing as vec_in
  cpu_out  input  DATA_W  CPU result port
  cpu_rst  output  1  active-high reset driven to the CPU
  cpu_in  output  DATA_W  stimulus driven to the CPU
  busy  output  1  high in every state other than IDLE and DONE
  done  output  1  high in DONE
  pass  output  1  in DONE, high when fail_count == 0
  fail_count  output  $clog2(N_VEC+1)  number of mismatching vectors
  vec_idx  output  $clog2(N_VEC) (min 1)  index of the current vector
  last_cycles  output  $clog2(RUN_CYC+1)  run cycles consumed by the most recently checked vector

Function
REQ-006 SHALL implement the states IDLE, HOLD, RUN, CHECK and DONE.
REQ-007 IDLE: on start, SHALL clear fail_count and vec_idx and go to HOLD.
REQ-008 HOLD: SHALL assert cpu_rst, drive cpu_in = vec_in[vec_idx] for exactly RST_CYC cycles, then go to RUN.
REQ-009 RUN: SHALL deassert cpu_rst, hold cpu_in stable and count cycles from 1.
REQ-010 RUN: SHALL go to CHECK when the count reaches RUN_CYC, or, if early_exit=1, in the first cycle in which cpu_out == vec_exp[vec_idx], whichever comes first.
REQ-011 CHECK: SHALL last one cycle; on cpu_out != vec_exp[vec_idx] SHALL increment fail_count; SHALL load last_cycles with the RUN count.
REQ-012 CHECK: if vec_idx == N_VEC-1, SHALL go to DONE; otherwise SHALL increment vec_idx and go to HOLD.
REQ-013 DONE: SHALL hold done, pass and fail_count stable; on start, SHALL restart exactly as from IDLE (same cycle semantics).
REQ-014 start SHALL be ignored in HOLD, RUN and CHECK.
REQ-015 fail_count SHALL saturate at N_VEC and never wrap.
REQ-016 early_exit SHALL be sampled on each RUN cycle; a change mid-run takes effect in the next cycle.
REQ-017 cpu_rst SHALL be high in IDLE, HOLD and DONE, and low in RUN and CHECK.
REQ-018 cpu_in SHALL be 0 in IDLE and hold its last vector value in DONE.
REQ-019 All outputs SHALL be registered (no combinational path from cpu_out to outputs).

Reset
REQ-020 While reset is low at a clock edge, SHALL enter IDLE with cpu_rst=1, cpu_in=0, busy=0, done=0, pass=0, fail_count=0, vec_idx=0, last_cycles=0.
REQ-021 Reset mid-sequence SHALL abort immediately; no partial results are retained.

Structure
REQ-022 A shared package SHALL hold the state enum and the width helper constants (index, fail and cycle widths).
REQ-023 One sub-module, run_counter (a loadable counter with terminal-count flag), SHALL be used for both the HOLD and RUN counts.

Verification
REQ-024 Reset sequence, N_VEC=4, defaults, CPU model out=in*2, vec_exp=2*vec_in, early_exit=0 -> every vector has exactly 1 HOLD cycle and 50 RUN cycles; done after 4*(1+50+1) cycles; pass=1; fail_count=0.
REQ-025 Same, with vec_exp[2] corrupted -> fail_count=1, pass=0, done asserted at the same cycle as in REQ-024.
REQ-026 early_exit=1, CPU model reaching the expected value on run cycle 7 -> last_cycles=7 for each vector; sequence length 4*(1+7+1).
REQ-027 All 4 vectors mismatching, N_VEC=4 -> fail_count=4 (saturated), and re-start from DONE clears it to 0 on the next sequence.
REQ-028 reset low at run cycle 20 of vector 1 -> next edge IDLE, cpu_rst=1, vec_idx=0, fail_count=0; a start pulse during RUN is ignored.

Source files
------------

// File: rtl/cpu_run_sequencer_pkg.sv
// Shared types and width helpers for the CPU run sequencer.
// Widths are functions because they depend on the instantiating module's parameters.
package cpu_run_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } state_t;

  function automatic int idx_w(input int n_vec);
    return (n_vec > 1) ? $clog2(n_vec) : 1;
  endfunction

  function automatic int fail_w(input int n_vec);
    return $clog2(n_vec + 1);
  endfunction

  function automatic int cyc_w(input int cyc);
    return $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/cpu_run_sequencer_run_counter.sv
// Loadable down-counter with a terminal-count flag, shared by the HOLD and RUN phases.
// tc marks the final cycle of a loaded interval (count value 1).
module run_counter
  import cpu_run_sequencer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == W'(1));

endmodule

// File: rtl/cpu_run_sequencer.sv
// Runs a CPU through N_VEC stimulus vectors: reset-hold, run, check, and tallies mismatches.
// state | meaning
// IDLE  | waiting for start, CPU held in reset, cpu_in = 0
// HOLD  | CPU in reset with the current vector applied, RST_CYC cycles
// RUN   | CPU released, counting run cycles until timeout or early match
// CHECK | one cycle: compare cpu_out, record run length, advance vector
// DONE  | results held until the next start
module cpu_run_sequencer
  import cpu_run_sequencer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int N_VEC   = 4,
  parameter int RST_CYC = 1,
  parameter int RUN_CYC = 50
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          early_exit,
  input  logic [N_VEC*DATA_W-1:0]       vec_in,
  input  logic [N_VEC*DATA_W-1:0]       vec_exp,
  input  logic [DATA_W-1:0]             cpu_out,
  output logic                          cpu_rst,
  output logic [DATA_W-1:0]             cpu_in,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [fail_w(N_VEC)-1:0]      fail_count,
  output logic [idx_w(N_VEC)-1:0]       vec_idx,
  output logic [cyc_w(RUN_CYC)-1:0]     last_cycles
);

  localparam int IW = idx_w(N_VEC);
  localparam int FW = fail_w(N_VEC);
  localparam int CW = cyc_w(RUN_CYC);
  localparam int HW = cyc_w(RST_CYC);
  localparam int KW = (CW > HW) ? CW : HW;

  state_t state_q, nxt;

  logic [DATA_W-1:0] in_arr  [N_VEC];
  logic [DATA_W-1:0] exp_arr [N_VEC];

  for (genvar g = 0; g < N_VEC; g++) begin : g_unpack
    assign in_arr[g]  = vec_in[g*DATA_W +: DATA_W];
    assign exp_arr[g] = vec_exp[g*DATA_W +: DATA_W];
  end

  logic          load, en, tc;
  logic [KW-1:0] load_val, cnt;
  logic          hit, exit_run, last_idx;

  assign hit      = (cpu_out == exp_arr[vec_idx]);
  assign exit_run = tc || (early_exit && hit);
  assign last_idx = (vec_idx == IW'(N_VEC - 1));

  // Counter is reloaded on entry to HOLD/RUN and frozen on the exit cycle,
  // so in CHECK it still holds the value of the last run cycle.
  assign load     = (nxt != state_q) && ((nxt == ST_HOLD) || (nxt == ST_RUN));
  assign load_val = (nxt == ST_RUN) ? KW'(RUN_CYC) : KW'(RST_CYC);
  assign en       = (nxt == state_q) && ((state_q == ST_HOLD) || (state_q == ST_RUN));

  run_counter #(.W(KW)) u_run_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .en       (en),
    .load_val (load_val),
    .cnt      (cnt),
    .tc       (tc)
  );

  logic                cpu_rst_d, busy_d, done_d, pass_d;
  logic [DATA_W-1:0]   cpu_in_d;
  logic [FW-1:0]       fail_d;
  logic [IW-1:0]       idx_d;
  logic [CW-1:0]       last_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cpu_rst     <= 1'b1;
      cpu_in      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_count  <= '0;
      vec_idx     <= '0;
      last_cycles <= '0;
    end else begin
      state_q     <= nxt;
      cpu_rst     <= cpu_rst_d;
      cpu_in      <= cpu_in_d;
      busy        <= busy_d;
      done        <= done_d;
      pass        <= pass_d;
      fail_count  <= fail_d;
      vec_idx     <= idx_d;
      last_cycles <= last_d;
    end
  end

  always_comb begin
    nxt = state_q;
    case (state_q)
      ST_IDLE,
      ST_DONE:  if (start) nxt = ST_HOLD;
      ST_HOLD:  if (tc) nxt = ST_RUN;
      ST_RUN:   if (exit_run) nxt = ST_CHECK;
      ST_CHECK: nxt = last_idx ? ST_DONE : ST_HOLD;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered above.
  always_comb begin
    idx_d    = vec_idx;
    fail_d   = fail_count;
    last_d   = last_cycles;
    cpu_in_d = cpu_in;
    if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start) begin
      idx_d  = '0;
      fail_d = '0;
    end
    if (state_q == ST_CHECK) begin
      if (!hit && (fail_count < FW'(N_VEC))) fail_d = fail_count + FW'(1);
      last_d = CW'(KW'(RUN_CYC) - cnt + KW'(1));
      if (!last_idx) idx_d = vec_idx + IW'(1);
    end
    if (nxt == ST_HOLD)      cpu_in_d = in_arr[idx_d];
    else if (nxt == ST_IDLE) cpu_in_d = '0;
    cpu_rst_d = (nxt == ST_IDLE) || (nxt == ST_HOLD) || (nxt == ST_DONE);
    busy_d    = !((nxt == ST_IDLE) || (nxt == ST_DONE));
    done_d    = (nxt == ST_DONE);
    pass_d    = done_d && (fail_d == '0);
  end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Bench for cpu_run_sequencer: CPU model out = 2*in after a programmable latency,
// per-vector scoreboard checked whenever a vector's run/check window closes.
module tb_cpu_run_sequencer;

  localparam int DATA_W  = 16;
  localparam int N_VEC   = 4;
  localparam int RST_CYC = 1;
  localparam int RUN_CYC = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset = 1'b0;
  logic                    start = 1'b0;
  logic                    early_exit = 1'b0;
  logic [N_VEC*DATA_W-1:0] vec_in = '0;
  logic [N_VEC*DATA_W-1:0] vec_exp = '0;
  logic [DATA_W-1:0]       cpu_out;
  logic                    cpu_rst;
  logic [DATA_W-1:0]       cpu_in;
  logic                    busy, done, pass;
  logic [2:0]              fail_count;
  logic [1:0]              vec_idx;
  logic [5:0]              last_cycles;

  cpu_run_sequencer #(
    .DATA_W(DATA_W), .N_VEC(N_VEC), .RST_CYC(RST_CYC), .RUN_CYC(RUN_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .early_exit(early_exit),
    .vec_in(vec_in), .vec_exp(vec_exp), .cpu_out(cpu_out),
    .cpu_rst(cpu_rst), .cpu_in(cpu_in), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .vec_idx(vec_idx), .last_cycles(last_cycles)
  );

  // CPU model: output matches 2*in from run cycle 'lat' onwards, off by one bit before.
  int lat = 1;
  int mcnt = 0;
  logic [DATA_W-1:0] dbl;
  assign dbl     = {cpu_in[DATA_W-2:0], 1'b0};
  assign cpu_out = (mcnt >= lat - 1) ? dbl : (dbl ^ 16'h0001);
  always @(posedge clk) begin
    if (cpu_rst) mcnt <= 0;
    else if (mcnt < 1000) mcnt <= mcnt + 1;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DATA_W-1:0] cin;
    int                cyc;
    int                hold;
  } exp_t;
  exp_t sb[$];

  logic [DATA_W-1:0] vin  [N_VEC];
  logic [DATA_W-1:0] vexp [N_VEC];
  int exp_fail;

  // Scoreboard monitor: a vector ends when cpu_rst rises after its low window.
  int hold_n = 0, low_n = 0;
  bit prev_low = 0;
  logic [DATA_W-1:0] run_in;
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      hold_n = 0; low_n = 0; prev_low = 0;
    end else begin
      if (prev_low && cpu_rst) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow got vector end want none pending");
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (low_n - 1 !== e.cyc) begin
            errors++; $display("FAIL sb_run_cycles got %0d want %0d", low_n - 1, e.cyc);
          end
          checks++;
          if (int'(last_cycles) !== e.cyc) begin
            errors++; $display("FAIL sb_last_cycles got %0d want %0d", last_cycles, e.cyc);
          end
          checks++;
          if (run_in !== e.cin) begin
            errors++; $display("FAIL sb_cpu_in got %h want %h", run_in, e.cin);
          end
          checks++;
          if (hold_n !== e.hold) begin
            errors++; $display("FAIL sb_hold_cycles got %0d want %0d", hold_n, e.hold);
          end
        end
        hold_n = 0; low_n = 0;
      end
      if (busy && cpu_rst) hold_n++;
      if (busy && !cpu_rst) begin
        low_n++;
        run_in = cpu_in;
      end
      prev_low = !cpu_rst;
    end
  end

  task automatic load_vectors();
    exp_fail = 0;
    for (int k = 0; k < N_VEC; k++) begin
      vec_in[k*DATA_W +: DATA_W]  = vin[k];
      vec_exp[k*DATA_W +: DATA_W] = vexp[k];
      if (vexp[k] != {vin[k][DATA_W-2:0], 1'b0} && exp_fail < N_VEC) exp_fail++;
    end
  endtask

  task automatic good_vectors();
    vin[0] = 16'h1234; vin[1] = 16'h0042; vin[2] = 16'h7ffe; vin[3] = 16'h0a0a;
    for (int k = 0; k < N_VEC; k++) vexp[k] = {vin[k][DATA_W-2:0], 1'b0};
  endtask

  task automatic push_exp(input int cyc0, input int cyc_rest);
    for (int k = 0; k < N_VEC; k++) begin
      exp_t e;
      e.cin  = vin[k];
      e.cyc  = (k == 0) ? cyc0 : cyc_rest;
      e.hold = RST_CYC;
      sb.push_back(e);
    end
  endtask

  // Caller is 1 time unit after a rising edge; n counts edges from the start edge to done.
  task automatic run_seq(input int toggle_at, output int n, output bit to,
                         output logic [2:0] f0, output logic b0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    f0 = fail_count; b0 = busy;
    n = 0; to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      n++;
      if (toggle_at != 0 && n == toggle_at) early_exit = 1'b1;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; early_exit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst got %b want 1", cpu_rst); end
    checks++; if (cpu_in !== '0) begin errors++; $display("FAIL reset_cpu_in got %h want 0", cpu_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
    checks++; if (fail_count !== '0) begin errors++; $display("FAIL reset_fail_count got %0d want 0", fail_count); end
    checks++; if (vec_idx !== '0) begin errors++; $display("FAIL reset_vec_idx got %0d want 0", vec_idx); end
    checks++; if (last_cycles !== '0) begin errors++; $display("FAIL reset_last_cycles got %0d want 0", last_cycles); end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++; $display("FAIL idle_stays busy=%b cpu_rst=%b want 0/1", busy, cpu_rst);
    end
  endtask

  // Shared end-of-sequence checks against the model's expected totals.
  task automatic seq_and_check(input string name, input int toggle_at, input int exp_n,
                               input int exp_last, input logic [DATA_W-1:0] exp_cin);
    int n; bit to; logic [2:0] f0; logic b0;
    run_seq(toggle_at, n, to, f0, b0);
    checks++;
    if (to) begin
      errors++; $display("FAIL %s_timeout got no done want done", name);
      sb.delete();
      return;
    end
    checks++; if (n !== exp_n) begin errors++; $display("FAIL %s_length got %0d want %0d", name, n, exp_n); end
    checks++; if (int'(fail_count) !== exp_fail) begin errors++; $display("FAIL %s_fail_count got %0d want %0d", name, fail_count, exp_fail); end
    checks++; if (pass !== (exp_fail == 0)) begin errors++; $display("FAIL %s_pass got %b want %b", name, pass, exp_fail == 0); end
    checks++; if (int'(last_cycles) !== exp_last) begin errors++; $display("FAIL %s_last_cycles got %0d want %0d", name, last_cycles, exp_last); end
    checks++; if (cpu_in !== exp_cin || cpu_rst !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_done_outputs cpu_in=%h cpu_rst=%b busy=%b want %h/1/0", name, cpu_in, cpu_rst, busy, exp_cin);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1'b1 || int'(fail_count) !== exp_fail) begin
      errors++; $display("FAIL %s_done_hold done=%b fail_count=%0d want 1/%0d", name, done, fail_count, exp_fail);
    end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL %s_sb_pending got %0d want 0", name, sb.size()); end
  endtask

  task automatic test_full_run();
    good_vectors(); load_vectors();
    lat = 1; early_exit = 1'b0;
    push_exp(RUN_CYC, RUN_CYC);
    seq_and_check("full_run", 0, N_VEC * (RST_CYC + RUN_CYC + 1), RUN_CYC, vin[N_VEC-1]);
  endtask

  task automatic test_corrupt();
    good_vectors();
    vexp[2] = vexp[2] ^ 16'h0100;
    load_vectors();
    lat = 1; early_exit = 1'b0;
    push_exp(RUN_CYC, RUN_CYC);
    seq_and_check("corrupt", 0, N_VEC * (RST_CYC + RUN_CYC + 1), RUN_CYC, vin[N_VEC-1]);
  endtask

  task automatic test_early_exit();
    good_vectors(); load_vectors();
    lat = 7; early_exit = 1'b1;
    push_exp(7, 7);
    seq_and_check("early_exit", 0, N_VEC * (RST_CYC + 7 + 1), 7, vin[N_VEC-1]);
    early_exit = 1'b0;
  endtask

  // early_exit raised during run cycle 10 of vector 0, after the CPU already matched.
  task automatic test_early_exit_toggle();
    good_vectors(); load_vectors();
    lat = 7; early_exit = 1'b0;
    push_exp(10, 7);
    seq_and_check("ee_toggle", 10, (RST_CYC + 10 + 1) + (N_VEC - 1) * (RST_CYC + 7 + 1), 7, vin[N_VEC-1]);
    early_exit = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n; bit to; logic [2:0] f0; logic b0;
    good_vectors();
    for (int k = 0; k < N_VEC; k++) vexp[k] = ~{vin[k][DATA_W-2:0], 1'b0};
    load_vectors();
    lat = 1; early_exit = 1'b0;
    push_exp(RUN_CYC, RUN_CYC);
    seq_and_check("all_fail", 0, N_VEC * (RST_CYC + RUN_CYC + 1), RUN_CYC, vin[N_VEC-1]);
    good_vectors(); load_vectors();
    push_exp(RUN_CYC, RUN_CYC);
    run_seq(0, n, to, f0, b0);
    checks++; if (f0 !== 3'd0 || b0 !== 1'b1) begin
      errors++; $display("FAIL restart_clear fail_count=%0d busy=%b want 0/1", f0, b0);
    end
    checks++; if (to || n !== N_VEC * (RST_CYC + RUN_CYC + 1)) begin
      errors++; $display("FAIL restart_length got %0d timeout=%b want %0d", n, to, N_VEC * (RST_CYC + RUN_CYC + 1));
    end
    checks++; if (pass !== 1'b1 || fail_count !== 3'd0) begin
      errors++; $display("FAIL restart_result pass=%b fail_count=%0d want 1/0", pass, fail_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    good_vectors(); load_vectors();
    lat = 1; early_exit = 1'b0;
    push_exp(RUN_CYC, RUN_CYC);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (71) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++; if (busy !== 1'b1 || cpu_rst !== 1'b0 || vec_idx !== 2'd1) begin
      errors++; $display("FAIL start_ignored busy=%b cpu_rst=%b vec_idx=%0d want 1/0/1", busy, cpu_rst, vec_idx);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (cpu_rst !== 1'b1 || vec_idx !== '0 || fail_count !== '0) begin
      errors++; $display("FAIL abort_state cpu_rst=%b vec_idx=%0d fail_count=%0d want 1/0/0", cpu_rst, vec_idx, fail_count);
    end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || cpu_in !== '0 || last_cycles !== '0) begin
      errors++; $display("FAIL abort_outputs busy=%b done=%b cpu_in=%h last_cycles=%0d want 0/0/0/0", busy, done, cpu_in, last_cycles);
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || sb.size() !== 0) begin
      errors++; $display("FAIL abort_idle busy=%b pending=%0d want 0/0", busy, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_corrupt();
    test_early_exit();
    test_early_exit_toggle();
    test_back_to_back();
    test_mid_reset();
    test_early_exit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
